io_port_responder: RTL and testbench
====================================

# io_port_responder

Memory-mapped I/O responder that sits on the processor's data-side bus opposite the core's load/store path and owns the external 8-bit input port and the 32-bit output port. Processor stores to the output register are buffered in a small FIFO and handed to the external consumer with a valid/ready handshake. The asynchronous input port is synchronized, captured, and flagged on change for the processor to poll.

## Interface
- FIFO_DEPTH, 4, output FIFO entries; power of two, 2..8
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- Select  in  1  address decoded into this block's I/O region
- MemWrite  in  1  store strobe, qualified by Select
- MemRead  in  1  load strobe, qualified by Select
- Address  in  4  byte offset within region; only [3:2] decoded
- WriteData  in  32  store data
- ReadData  out  32  load data, combinational from current register state
- PortIn  in  8  external input, asynchronous to clk
- PortOut  out  32  FIFO head entry
- PortOutValid  out  1  FIFO non-empty
- PortOutReady  in  1  consumer accepts head this cycle

## Operation
- Register map (Address[3:2]):
  - 0 TXDATA: write pushes WriteData into FIFO; read returns 0.
  - 1 RXDATA: read returns {24'b0, synchronized PortIn}; read clears CHG.
  - 2 STATUS: read returns {24'b0, COUNT[3:0], OVF, CHG, EMPTY, FULL} (bit0 = FULL); writes ignored.
  - 3 CONTROL: write bit0=1 clears OVF, bit1=1 flushes FIFO; read returns 0.
- Access is active only when Select=1; MemRead/MemWrite without Select has no effect, and ReadData=0 when Select=0 or MemRead=0.
- Push accepted when !FULL, or when FULL and a pop occurs in the same cycle. Push refused when FULL with no pop: data dropped, OVF set (sticky).
- Pop occurs when PortOutValid && PortOutReady; head advances at the edge.
- Flush has priority over push and pop in the same cycle. FIFO empties, the push is discarded, and OVF is unchanged.
- OVF set and clear in the same cycle: set wins. CHG set and clear (RXDATA read) in the same cycle: set wins.
- Input path: 2-flop synchronizer (sync1, sync2), then prev register. CHG is set when sync2 != prev.
- Pointers wrap modulo FIFO_DEPTH. COUNT ranges 0..FIFO_DEPTH. FULL = (COUNT==FIFO_DEPTH), EMPTY = (COUNT==0).
- With MemRead and MemWrite both asserted, ReadData reflects pre-edge state and the write takes effect at the edge.

## Timing
- Reset (async assert, sync-safe deassert handled upstream) clears the following:
  - pointers and COUNT to 0
  - all FIFO storage to 0, so PortOut=0
  - PortOutValid=0
  - OVF=0, CHG=0
  - sync1, sync2, and prev to 0
  - ReadData follows register state, giving STATUS=0x02
- Reset mid-transfer discards all FIFO contents. No partial handshake survives.
- Push at edge N: PortOutValid=1 and PortOut=data in cycle N+1. There is no combinational path from WriteData to PortOut.
- Handshake: while PortOutValid=1 and PortOutReady=0, PortOut and PortOutValid hold stable. Ready may be asserted with Valid low, with no effect.
- Back-to-back pops sustain 1 entry/cycle.
- PortIn change before edge 1: sync2 (RXDATA) updates after edge 2, and CHG reads 1 after edge 3. Pulses narrower than one clock may be missed.
- STATUS/RXDATA reads are zero-wait, valid in the same cycle as MemRead.

## Test plan
- Reset, then release → STATUS reads 0x00000002, PortOutValid=0, PortOut=0, ReadData of RXDATA=0.
- Push 0xA5A5_0001..0xA5A5_0004 with Ready=0 → FULL, STATUS=0x00000041. A fifth push of 0xDEAD_BEEF → dropped, STATUS=0x00000049. Then Ready=1 for 4 cycles → PortOut sequence 0xA5A5_0001..0004, then PortOutValid=0.
- FIFO full, with push 0x1234_5678 and pop in the same cycle → push accepted, OVF stays 0, COUNT stays 4, and 0x1234_5678 emerges last.
- PortIn 0x00→0x3C → RXDATA=0x3C after 2 edges, CHG=1 after 3 edges. Read RXDATA → CHG=0 next cycle. If PortIn changes again in the same cycle as the clearing read → CHG remains 1.
- With 3 entries queued, write CONTROL=0x3 together with Ready=1 → EMPTY=1 and OVF=0 next cycle, with no extra pop observed beyond the flush.
- Assert reset with 2 entries queued and Valid=1 → Valid drops immediately (async), and after release STATUS=0x00000002.

Source files
------------

// File: rtl/io_port_responder.sv
// Memory-mapped I/O responder: buffers processor stores to the output port in a small FIFO
// with a valid/ready handoff, and synchronizes and change-flags the external input port.
module io_port_responder #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Select,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [3:0]  Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   input  logic [7:0]  PortIn,
   output logic [31:0] PortOut,
   output logic        PortOutValid,
   input  logic        PortOutReady
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_RXDATA  = 2'd1;
   localparam logic [1:0] REG_STATUS  = 2'd2;
   localparam logic [1:0] REG_CONTROL = 2'd3;

   logic [31:0]      fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W-1:0] wrPtr;
   logic [CNT_W-1:0] count;
   logic             ovf;
   logic             chg;
   logic [7:0]       sync1;
   logic [7:0]       sync2;
   logic [7:0]       prevIn;

   logic [1:0] regSel;
   logic       wrEn;
   logic       rdEn;
   logic       full;
   logic       empty;
   logic       pushReq;
   logic       pushAcc;
   logic       pop;
   logic       flush;
   logic       ovfSet;
   logic       ovfClr;
   logic       chgSet;
   logic       chgClr;
   logic [3:0] count4;
   logic [7:0] status8;
   logic [1:0] unusedAddrBits;

   assign unusedAddrBits = Address[1:0];

   assign regSel  = Address[3:2];
   assign wrEn    = Select && MemWrite;
   assign rdEn    = Select && MemRead;
   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign empty   = (count == '0);

   // Flush outranks push and pop; a push into a full FIFO still lands if the head leaves this cycle.
   assign pop     = !empty && PortOutReady;
   assign flush   = wrEn && (regSel == REG_CONTROL) && WriteData[1];
   assign pushReq = wrEn && (regSel == REG_TXDATA) && !flush;
   assign pushAcc = pushReq && (!full || pop);
   assign ovfSet  = pushReq && full && !pop;
   assign ovfClr  = wrEn && (regSel == REG_CONTROL) && WriteData[0];
   assign chgSet  = (sync2 != prevIn);
   assign chgClr  = rdEn && (regSel == REG_RXDATA);

   assign PortOut      = fifoMem[rdPtr];
   assign PortOutValid = !empty;

   assign count4  = 4'(count);
   assign status8 = {count4, ovf, chg, empty, full};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifoMem[i] <= '0;
         end
      end else if (flush) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (pushAcc) begin
            fifoMem[wrPtr] <= WriteData;
            wrPtr          <= wrPtr + PTR_W'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + PTR_W'(1);
         end
         if (pushAcc && !pop) begin
            count <= count + CNT_W'(1);
         end else if (!pushAcc && pop) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   // Sticky flags: a set in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf <= 1'b0;
         chg <= 1'b0;
      end else begin
         if (ovfSet) begin
            ovf <= 1'b1;
         end else if (ovfClr) begin
            ovf <= 1'b0;
         end
         if (chgSet) begin
            chg <= 1'b1;
         end else if (chgClr) begin
            chg <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1  <= '0;
         sync2  <= '0;
         prevIn <= '0;
      end else begin
         sync1  <= PortIn;
         sync2  <= sync1;
         prevIn <= sync2;
      end
   end

   always_comb begin
      ReadData = '0;
      if (rdEn) begin
         case (regSel)
            REG_RXDATA: ReadData = {24'b0, sync2};
            REG_STATUS: ReadData = {24'b0, status8};
            default:    ReadData = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_io_port_responder.sv
// Self-checking bench for io_port_responder: a scoreboard queue holds accepted pushes and a
// negedge monitor compares every observed pop against it; scenario tasks check registers.
module tb_io_port_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        Select = 1'b0;
   logic        MemWrite = 1'b0;
   logic        MemRead = 1'b0;
   logic [3:0]  Address = '0;
   logic [31:0] WriteData = '0;
   logic [31:0] ReadData;
   logic [7:0]  PortIn = '0;
   logic [31:0] PortOut;
   logic        PortOutValid;
   logic        PortOutReady = 1'b0;

   int          checks = 0;
   int          errors = 0;
   int          popCount = 0;
   bit          flushing = 1'b0;
   logic [31:0] expQ [$];
   logic [31:0] monExp;
   logic [31:0] rd;

   io_port_responder #(.FIFO_DEPTH(4)) dut (
      .clk(clk),
      .reset(reset),
      .Select(Select),
      .MemWrite(MemWrite),
      .MemRead(MemRead),
      .Address(Address),
      .WriteData(WriteData),
      .ReadData(ReadData),
      .PortIn(PortIn),
      .PortOut(PortOut),
      .PortOutValid(PortOutValid),
      .PortOutReady(PortOutReady)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Every handshake seen before a rising edge is a pop; its data must match the scoreboard head.
   always @(negedge clk) begin
      if (reset && !flushing && PortOutValid && PortOutReady) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL pop_unexpected: got %h, required no pop", PortOut);
         end else begin
            monExp = expQ.pop_front();
            if (PortOut !== monExp) begin
               errors++;
               $display("[TB] FAIL pop_data: got %h, required %h", PortOut, monExp);
            end
         end
         popCount++;
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
      Select    = 1'b1;
      MemWrite  = 1'b1;
      Address   = a;
      WriteData = d;
      cycle();
      Select    = 1'b0;
      MemWrite  = 1'b0;
   endtask

   task automatic peekReg(input logic [3:0] a, output logic [31:0] d);
      Select  = 1'b1;
      MemRead = 1'b1;
      Address = a;
      #1;
      d       = ReadData;
      Select  = 1'b0;
      MemRead = 1'b0;
   endtask

   task automatic readClocked(input logic [3:0] a, output logic [31:0] d);
      Select  = 1'b1;
      MemRead = 1'b1;
      Address = a;
      #1;
      d       = ReadData;
      cycle();
      Select  = 1'b0;
      MemRead = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) cycle();
      reset = 1'b1;
      peekReg(4'h8, rd);
      checks++;
      if (rd !== 32'h0000_0002) begin
         errors++;
         $display("[TB] FAIL reset_status: got %h, required %h", rd, 32'h2);
      end
      checks++;
      if (PortOutValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_valid: got %b, required 0", PortOutValid);
      end
      checks++;
      if (PortOut !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_portout: got %h, required 0", PortOut);
      end
      peekReg(4'h4, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_rxdata: got %h, required 0", rd);
      end
      Select  = 1'b0;
      MemRead = 1'b1;
      Address = 4'h8;
      #1;
      checks++;
      if (ReadData !== 32'h0) begin
         errors++;
         $display("[TB] FAIL unselected_read: got %h, required 0", ReadData);
      end
      MemRead = 1'b0;
   endtask

   task automatic test_fill_overflow();
      PortOutReady = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         expQ.push_back(32'hA5A5_0000 + 32'(i));
         busWrite(4'h0, 32'hA5A5_0000 + 32'(i));
         if (i == 1) begin
            checks++;
            if (PortOutValid !== 1'b1 || PortOut !== 32'hA5A5_0001) begin
               errors++;
               $display("[TB] FAIL push_latency: got valid=%b data=%h, required valid=1 data=a5a50001",
                        PortOutValid, PortOut);
            end
         end
      end
      peekReg(4'h8, rd);
      checks++;
      if (rd !== 32'h0000_0041) begin
         errors++;
         $display("[TB] FAIL full_status: got %h, required %h", rd, 32'h41);
      end
      busWrite(4'h0, 32'hDEAD_BEEF);
      peekReg(4'h8, rd);
      checks++;
      if (rd !== 32'h0000_0049) begin
         errors++;
         $display("[TB] FAIL overflow_status: got %h, required %h", rd, 32'h49);
      end
      checks++;
      if (PortOut !== 32'hA5A5_0001 || PortOutValid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL hold_head: got valid=%b data=%h, required valid=1 data=a5a50001",
                  PortOutValid, PortOut);
      end
      PortOutReady = 1'b1;
      repeat (4) cycle();
      PortOutReady = 1'b0;
      checks++;
      if (PortOutValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL drained_valid: got %b, required 0", PortOutValid);
      end
   endtask

   task automatic test_select_gating();
      Select    = 1'b0;
      MemWrite  = 1'b1;
      Address   = 4'hC;
      WriteData = 32'h1;
      cycle();
      Address   = 4'h0;
      WriteData = 32'h5555_5555;
      cycle();
      MemWrite  = 1'b0;
      peekReg(4'h8, rd);
      checks++;
      if (rd !== 32'h0000_000A) begin
         errors++;
         $display("[TB] FAIL unselected_write: got %h, required %h", rd, 32'hA);
      end
      busWrite(4'hC, 32'h1);
      peekReg(4'h8, rd);
      checks++;
      if (rd !== 32'h0000_0002) begin
         errors++;
         $display("[TB] FAIL ovf_clear: got %h, required %h", rd, 32'h2);
      end
   endtask

   task automatic test_full_push_pop();
      PortOutReady = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         expQ.push_back(32'hB000_0000 + 32'(i));
         busWrite(4'h0, 32'hB000_0000 + 32'(i));
      end
      expQ.push_back(32'h1234_5678);
      PortOutReady = 1'b1;
      busWrite(4'h0, 32'h1234_5678);
      PortOutReady = 1'b0;
      peekReg(4'h8, rd);
      checks++;
      if (rd !== 32'h0000_0041) begin
         errors++;
         $display("[TB] FAIL push_pop_full_status: got %h, required %h", rd, 32'h41);
      end
      PortOutReady = 1'b1;
      repeat (4) cycle();
      PortOutReady = 1'b0;
      checks++;
      if (PortOutValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL push_pop_drained: got %b, required 0", PortOutValid);
      end
   endtask

   task automatic test_input_sync();
      PortIn = 8'h3C;
      peekReg(4'h4, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("[TB] FAIL sync_edge0: got %h, required 0", rd);
      end
      cycle();
      peekReg(4'h4, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("[TB] FAIL sync_edge1: got %h, required 0", rd);
      end
      cycle();
      peekReg(4'h4, rd);
      checks++;
      if (rd !== 32'h0000_003C) begin
         errors++;
         $display("[TB] FAIL sync_edge2: got %h, required %h", rd, 32'h3C);
      end
      peekReg(4'h8, rd);
      checks++;
      if (rd !== 32'h0000_0002) begin
         errors++;
         $display("[TB] FAIL chg_edge2: got %h, required %h", rd, 32'h2);
      end
      cycle();
      peekReg(4'h8, rd);
      checks++;
      if (rd !== 32'h0000_0006) begin
         errors++;
         $display("[TB] FAIL chg_edge3: got %h, required %h", rd, 32'h6);
      end
      readClocked(4'h4, rd);
      peekReg(4'h8, rd);
      checks++;
      if (rd !== 32'h0000_0002) begin
         errors++;
         $display("[TB] FAIL chg_cleared: got %h, required %h", rd, 32'h2);
      end
      PortIn = 8'h81;
      cycle();
      cycle();
      readClocked(4'h4, rd);
      checks++;
      if (rd !== 32'h0000_0081) begin
         errors++;
         $display("[TB] FAIL rx_second: got %h, required %h", rd, 32'h81);
      end
      peekReg(4'h8, rd);
      checks++;
      if (rd !== 32'h0000_0006) begin
         errors++;
         $display("[TB] FAIL chg_set_wins: got %h, required %h", rd, 32'h6);
      end
      readClocked(4'h4, rd);
      peekReg(4'h8, rd);
      checks++;
      if (rd !== 32'h0000_0002) begin
         errors++;
         $display("[TB] FAIL chg_final_clear: got %h, required %h", rd, 32'h2);
      end
   endtask

   task automatic test_flush();
      int popBefore;
      PortOutReady = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         expQ.push_back(32'hC000_0000 + 32'(i));
         busWrite(4'h0, 32'hC000_0000 + 32'(i));
      end
      busWrite(4'h0, 32'hDEAD_0005);
      PortOutReady = 1'b1;
      cycle();
      PortOutReady = 1'b0;
      peekReg(4'h8, rd);
      checks++;
      if (rd !== 32'h0000_0038) begin
         errors++;
         $display("[TB] FAIL preflush_status: got %h, required %h", rd, 32'h38);
      end
      popBefore    = popCount;
      flushing     = 1'b1;
      PortOutReady = 1'b1;
      busWrite(4'hC, 32'h3);
      expQ.delete();
      flushing     = 1'b0;
      peekReg(4'h8, rd);
      checks++;
      if (rd !== 32'h0000_0002 || PortOutValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_status: got %h valid=%b, required 00000002 valid=0", rd, PortOutValid);
      end
      cycle();
      PortOutReady = 1'b0;
      checks++;
      if (popCount !== popBefore) begin
         errors++;
         $display("[TB] FAIL flush_extra_pop: got %0d pops, required %0d", popCount, popBefore);
      end
   endtask

   task automatic test_reset_midstream();
      PortOutReady = 1'b0;
      expQ.push_back(32'hD000_0001);
      busWrite(4'h0, 32'hD000_0001);
      expQ.push_back(32'hD000_0002);
      busWrite(4'h0, 32'hD000_0002);
      checks++;
      if (PortOutValid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL pre_reset_valid: got %b, required 1", PortOutValid);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (PortOutValid !== 1'b0 || PortOut !== 32'h0) begin
         errors++;
         $display("[TB] FAIL async_reset: got valid=%b data=%h, required valid=0 data=0", PortOutValid, PortOut);
      end
      expQ.delete();
      cycle();
      cycle();
      reset = 1'b1;
      peekReg(4'h8, rd);
      checks++;
      if (rd !== 32'h0000_0002) begin
         errors++;
         $display("[TB] FAIL post_reset_status: got %h, required %h", rd, 32'h2);
      end
   endtask

   initial begin
      $display("[TB] starting io_port_responder bench");
      test_reset();
      test_fill_overflow();
      test_select_gating();
      test_full_push_pop();
      test_input_sync();
      test_flush();
      test_reset_midstream();
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_leftover: got %0d entries, required 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
